seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter NDIGITS, default 4: number of multiplexed 7-segment digits (range 1..8).
REQ-002 Parameter BUF_DEPTH, default 8: message buffer depth in character codes (power of two, at least 2).
REQ-003 Parameter SCAN_DIV, default 4: clock cycles each digit stays selected.
REQ-004 Parameter STEP_DIV, default 8: scan frames per scroll step or blink half-period; one frame is NDIGITS*SCAN_DIV cycles.
REQ-005 Ports, as name / direction / width / meaning:
- clk_2  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  append wr_data to the buffer.
- wr_data  in  6  character code.
- clear  in  1  empty the buffer.
- mode  in  2  00 static, 01 scroll, 10 blink, 11 treated as static.
- count  out  $clog2(BUF_DEPTH)+1  number of stored codes.
- full  out  1  count equals BUF_DEPTH.
- dig_sel  out  NDIGITS  one-hot, active-high digit enable.
- seg  out  7  segment pattern, bit0=a … bit6=g, active-high.

Function
REQ-006 Glyph map, codes to patterns:
- 0-15: hex digits 0-9, A, b, C, d, E, F (0=0111111, 1=0000110, 8=1111111, F=1110001).
- 16-41: A b C c d E F g H h I i J L n O o P q r S t U u y and the degree sign, in that order.
- 63: blank, 0000000.
- 42-62: dash, 1000000.
REQ-007 Buffer writes:
- wr_en with full=0 stores wr_data at index count; count increments on the next edge.
- wr_en with full=1 is ignored, with no state change.
REQ-008 clear sets count to 0 on the next edge; clear and wr_en in the same cycle: clear wins and the write is discarded.
REQ-009 Scan counter: counts 0..SCAN_DIV-1; on wrap, dig_sel rotates from digit d to digit (d+1) mod NDIGITS, starting at digit 0.
REQ-010 Frame boundary: each transition from digit NDIGITS-1 to digit 0 is a frame boundary and advances the step counter, which counts 0..STEP_DIV-1.
REQ-011 Selected code for digit d, with base register B:
- count=0: blank.
- Static and blink modes: buffer entry d if d < count, otherwise blank.
- Scroll mode: buffer entry (B+d) mod count.
REQ-012 Scroll mode: each step-counter wrap advances B by 1; B wraps to 0 when B+1 equals count.
REQ-013 Blink mode:
- A phase bit toggles on each step-counter wrap.
- Phase 1: seg is forced to 0000000 while dig_sel keeps scanning.
- Phase 0: seg is shown normally.
REQ-014 Any change of mode clears B, the step counter and the blink phase to 0 on the next edge; the scan counter is unaffected.
REQ-015 clear, or a write while count is 0, also clears B to 0.
REQ-016 A write while scrolling leaves B unchanged.
REQ-017 Output timing: dig_sel and seg are registered and always describe the same digit.
REQ-018 Write latency: a write is visible on seg at the next register update that selects that digit, at most SCAN_DIV*NDIGITS+1 cycles after the write edge.
REQ-019 full and count are registered and reflect all writes and clears made up to the previous edge.

Reset
REQ-020 reset=1 at a rising edge sets the following, overriding wr_en, clear and mode:
- count=0, full=0.
- B=0, scan counter=0, step counter=0, blink phase=0.
- dig_sel = one-hot digit 0 (value 1).
- seg=0000000.
REQ-021 Buffer contents need not be cleared by reset; entries at index count or above are never displayed.
REQ-022 Reset asserted mid-frame or mid-scroll restarts scanning at digit 0 on the first edge after reset deasserts.

Structure
REQ-023 Shared package seg7_pkg holds:
- the mode encoding as an enumerated type;
- code constants CODE_BLANK=63 and CODE_DASH=42;
- the segment pattern constants SEG_BLANK and SEG_DASH.
REQ-024 Glyph decode is one combinational sub-module, seg7_glyph (6-bit code in, 7-bit pattern out), instantiated once after the digit mux.

Verification
REQ-025 Reset, then write codes 1,2,3,4 in static mode → over one frame, dig_sel 0001/0010/0100/1000 shows seg 0000110/1011011/1001111/1100110.
REQ-026 Write 9 codes with BUF_DEPTH=8 → full=1 and count=8 after the 8th write; the 9th write leaves the buffer and count unchanged.
REQ-027 Codes 16,24,29,31 (AHLO) in scroll mode with count=4 → after STEP_DIV frames digit 0 shows H (1110110); after 4 steps, A again.
REQ-028 Blink mode with code 8 → seg is 1111111 for STEP_DIV frames, then 0000000 for STEP_DIV frames, with dig_sel scanning throughout.
REQ-029 clear and wr_en (code 5) in the same cycle → count=0 and all digits blank; then code 50 → digit 0 shows dash 1000000.
REQ-030 reset pulse mid-scroll at B=2 → next cycle dig_sel=0001, count=0, seg=0000000.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment message scanner.
package seg7_pkg;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_SCROLL = 2'b01,
      MODE_BLINK  = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   localparam logic [5:0] CODE_BLANK = 6'd63;
   localparam logic [5:0] CODE_DASH  = 6'd42;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_DASH  = 7'b1000000;

   // The reserved encoding behaves as static, so it is folded in before any mode compare.
   function automatic mode_e mode_norm(input logic [1:0] m);
      case (m)
         2'b01:   return MODE_SCROLL;
         2'b10:   return MODE_BLINK;
         default: return MODE_STATIC;
      endcase
   endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Character code to segment pattern decode; pattern bit0=a .. bit6=g, active-high.
module seg7_glyph
   import seg7_pkg::*;
(
   input  logic [5:0] code,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (code)
         6'd0:  seg = 7'h3F;
         6'd1:  seg = 7'h06;
         6'd2:  seg = 7'h5B;
         6'd3:  seg = 7'h4F;
         6'd4:  seg = 7'h66;
         6'd5:  seg = 7'h6D;
         6'd6:  seg = 7'h7D;
         6'd7:  seg = 7'h07;
         6'd8:  seg = 7'h7F;
         6'd9:  seg = 7'h6F;
         6'd10: seg = 7'h77;
         6'd11: seg = 7'h7C;
         6'd12: seg = 7'h39;
         6'd13: seg = 7'h5E;
         6'd14: seg = 7'h79;
         6'd15: seg = 7'h71;
         // Letters: A b C c d E F g H h I i J L n O o P q r S t U u y degree
         6'd16: seg = 7'h77;
         6'd17: seg = 7'h7C;
         6'd18: seg = 7'h39;
         6'd19: seg = 7'h58;
         6'd20: seg = 7'h5E;
         6'd21: seg = 7'h79;
         6'd22: seg = 7'h71;
         6'd23: seg = 7'h6F;
         6'd24: seg = 7'h76;
         6'd25: seg = 7'h74;
         6'd26: seg = 7'h06;
         6'd27: seg = 7'h04;
         6'd28: seg = 7'h1E;
         6'd29: seg = 7'h38;
         6'd30: seg = 7'h54;
         6'd31: seg = 7'h3F;
         6'd32: seg = 7'h5C;
         6'd33: seg = 7'h73;
         6'd34: seg = 7'h67;
         6'd35: seg = 7'h50;
         6'd36: seg = 7'h6D;
         6'd37: seg = 7'h78;
         6'd38: seg = 7'h3E;
         6'd39: seg = 7'h1C;
         6'd40: seg = 7'h6E;
         6'd41: seg = 7'h63;
         CODE_BLANK: seg = SEG_BLANK;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan.sv
// Message buffer plus digit scanner for a multiplexed 7-segment display with
// static, scrolling and blinking presentation.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int NDIGITS   = 4,
   parameter int BUF_DEPTH = 8,
   parameter int SCAN_DIV  = 4,
   parameter int STEP_DIV  = 8
) (
   input  logic                         clk_2,
   input  logic                         reset,
   input  logic                         wr_en,
   input  logic [5:0]                   wr_data,
   input  logic                         clear,
   input  logic [1:0]                   mode,
   output logic [$clog2(BUF_DEPTH):0]   count,
   output logic                         full,
   output logic [NDIGITS-1:0]           dig_sel,
   output logic [6:0]                   seg
);

   localparam int AW = $clog2(BUF_DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int IW = CW + 4;

   localparam logic [DW-1:0] DIG_LAST  = DW'(NDIGITS - 1);
   localparam logic [SW-1:0] SCAN_LOAD = SW'(SCAN_DIV - 1);
   localparam logic [TW-1:0] STEP_LOAD = TW'(STEP_DIV - 1);

   logic [5:0]         mem_q [BUF_DEPTH];
   logic [CW-1:0]      count_q, count_d;
   logic               full_q, full_d;
   logic [CW-1:0]      base_q, base_d;
   logic [SW-1:0]      scan_q, scan_d;
   logic [DW-1:0]      digit_q, digit_d;
   logic [TW-1:0]      step_q, step_d;
   logic               phase_q, phase_d;
   mode_e              mode_q, mode_d;
   logic [NDIGITS-1:0] dig_sel_q, dig_sel_d;
   logic [6:0]         seg_q, seg_d;

   mode_e         mode_cur;
   logic          mode_chg, wr_ok, scan_tc, frame_tick, step_tc, show;
   logic [IW-1:0] rd_idx;
   logic [5:0]    code_sel;
   logic [6:0]    glyph;

   // Scan and step timers are down-counters; terminal count at zero marks the wrap.
   always_comb begin
      mode_cur   = mode_norm(mode);
      mode_d     = mode_cur;
      mode_chg   = (mode_cur != mode_q);
      wr_ok      = wr_en && !full_q && !clear;
      scan_tc    = (scan_q == '0);
      frame_tick = scan_tc && (digit_q == DIG_LAST);
      step_tc    = frame_tick && (step_q == '0);

      count_d = count_q;
      if (clear)      count_d = '0;
      else if (wr_ok) count_d = count_q + CW'(1);
      full_d = (count_d == CW'(BUF_DEPTH));

      scan_d  = scan_tc ? SCAN_LOAD : scan_q - 1'b1;
      digit_d = digit_q;
      if (scan_tc) digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;

      step_d = step_q;
      if (frame_tick) step_d = step_tc ? STEP_LOAD : step_q - 1'b1;
      phase_d = phase_q ^ step_tc;

      base_d = base_q;
      if (mode_cur == MODE_SCROLL && step_tc && count_q != '0)
         base_d = (base_q + CW'(1) == count_q) ? '0 : base_q + CW'(1);
      if (mode_chg) begin
         step_d  = STEP_LOAD;
         phase_d = 1'b0;
         base_d  = '0;
      end
      if (clear || (wr_ok && count_q == '0)) base_d = '0;

      // Display uses next-cycle base/phase so a new step lands together with digit 0.
      rd_idx = IW'(digit_d);
      if (mode_cur == MODE_SCROLL) begin
         rd_idx = IW'(base_d) + IW'(digit_d);
         for (int i = 0; i < NDIGITS; i++)
            if (rd_idx >= IW'(count_q)) rd_idx = rd_idx - IW'(count_q);
      end
      show     = (count_q != '0) && (rd_idx < IW'(count_q));
      code_sel = show ? mem_q[rd_idx[AW-1:0]] : CODE_BLANK;

      dig_sel_d = NDIGITS'(1) << digit_d;
      seg_d     = (mode_cur == MODE_BLINK && phase_d) ? SEG_BLANK : glyph;
   end

   seg7_glyph u_glyph (
      .code (code_sel),
      .seg  (glyph)
   );

   always_ff @(posedge clk_2) begin
      if (reset) begin
         count_q   <= '0;
         full_q    <= 1'b0;
         base_q    <= '0;
         scan_q    <= SCAN_LOAD;
         digit_q   <= '0;
         step_q    <= STEP_LOAD;
         phase_q   <= 1'b0;
         mode_q    <= mode_cur;
         dig_sel_q <= NDIGITS'(1);
         seg_q     <= SEG_BLANK;
      end else begin
         count_q   <= count_d;
         full_q    <= full_d;
         base_q    <= base_d;
         scan_q    <= scan_d;
         digit_q   <= digit_d;
         step_q    <= step_d;
         phase_q   <= phase_d;
         mode_q    <= mode_d;
         dig_sel_q <= dig_sel_d;
         seg_q     <= seg_d;
      end
   end

   // Storage is deliberately not reset; entries at or above count are never shown.
   always_ff @(posedge clk_2) begin
      if (!reset && wr_ok) mem_q[count_q[AW-1:0]] <= wr_data;
   end

   assign count   = count_q;
   assign full    = full_q;
   assign dig_sel = dig_sel_q;
   assign seg     = seg_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: glyph table, buffer limits, scroll, blink, clear and reset.
module tb_seg7_scan;

   localparam int FR = 16;

   typedef struct packed {
      logic [5:0] code;
      logic [6:0] exp;
   } gvec_t;

   logic       clk_2 = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [5:0] wr_data = 6'd0;
   logic       clear = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [3:0] count;
   logic       full;
   logic [3:0] dig_sel;
   logic [6:0] seg;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int m_cyc = 0;

   seg7_scan #(.NDIGITS(4), .BUF_DEPTH(8), .SCAN_DIV(4), .STEP_DIV(8)) dut (
      .clk_2   (clk_2),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .clear   (clear),
      .mode    (mode),
      .count   (count),
      .full    (full),
      .dig_sel (dig_sel),
      .seg     (seg)
   );

   always #5 clk_2 = ~clk_2;
   always @(posedge clk_2) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_2);
   endtask

   task automatic wr(input logic [5:0] c);
      wr_en = 1'b1;
      wr_data = c;
      tick(1);
      wr_en = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
   endtask

   task automatic wait_digit(input int d);
      int n = 0;
      logic [3:0] want;
      want = 4'(1 << d);
      while (dig_sel !== want && n < 64) begin
         tick(1);
         n++;
      end
      chk($sformatf("dig_sel_%0d", d), 32'(dig_sel), 32'(want));
   endtask

   task automatic seg_at(input string name, input int d, input logic [6:0] exp);
      wait_digit(d);
      chk(name, 32'(seg), 32'(exp));
   endtask

   task automatic set_mode(input logic [1:0] m);
      mode = m;
      tick(1);
      m_cyc = cyc;
   endtask

   task automatic wait_rel(input int t);
      int n = 0;
      while ((cyc - m_cyc) < t && n < 4000) begin
         tick(1);
         n++;
      end
   endtask

   gvec_t      gv [16];
   logic [6:0] exp_static [4];

   initial begin
      gv = '{
         '{6'd0,  7'h3F}, '{6'd1,  7'h06}, '{6'd8,  7'h7F}, '{6'd9,  7'h6F},
         '{6'd10, 7'h77}, '{6'd15, 7'h71}, '{6'd16, 7'h77}, '{6'd19, 7'h58},
         '{6'd24, 7'h76}, '{6'd29, 7'h38}, '{6'd31, 7'h3F}, '{6'd41, 7'h63},
         '{6'd42, 7'h40}, '{6'd50, 7'h40}, '{6'd62, 7'h40}, '{6'd63, 7'h00}
      };
      exp_static = '{7'h06, 7'h5B, 7'h4F, 7'h66};

      // Reset state
      tick(3);
      chk("rst_dig_sel", 32'(dig_sel), 32'h1);
      chk("rst_seg", 32'(seg), 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_full", 32'(full), 32'h0);
      reset = 1'b0;

      // Static display of 1,2,3,4
      for (int i = 1; i <= 4; i++) wr(6'(i));
      chk("static_count", 32'(count), 32'd4);
      tick(FR + 2);
      for (int d = 0; d < 4; d++) seg_at($sformatf("static_seg_%0d", d), d, exp_static[d]);

      // Fill to capacity and one write beyond
      do_clear();
      chk("clear_count", 32'(count), 32'd0);
      for (int i = 0; i < 9; i++) begin
         wr(6'(i));
         if (i == 6) begin
            chk("count_7", 32'(count), 32'd7);
            chk("full_at_7", 32'(full), 32'd0);
         end
         if (i >= 7) begin
            chk($sformatf("count_after_wr%0d", i + 1), 32'(count), 32'd8);
            chk($sformatf("full_after_wr%0d", i + 1), 32'(full), 32'd1);
         end
      end
      tick(FR + 2);
      seg_at("full_seg_0", 0, 7'h3F);
      seg_at("full_seg_3", 3, 7'h4F);

      // Glyph table through digit 0
      for (int i = 0; i < 16; i++) begin
         do_clear();
         wr(gv[i].code);
         tick(FR + 2);
         seg_at($sformatf("glyph_%0d", gv[i].code), 0, gv[i].exp);
      end
      seg_at("unused_digit_blank", 1, 7'h00);

      // Reserved mode behaves as static
      do_clear();
      wr(6'd16); wr(6'd24); wr(6'd29); wr(6'd31);
      mode = 2'b11;
      tick(FR + 2);
      seg_at("mode11_seg_2", 2, 7'h38);
      mode = 2'b00;
      tick(2);

      // Clear wins over a simultaneous write
      do_clear();
      wr(6'd7);
      clear = 1'b1; wr_en = 1'b1; wr_data = 6'd5;
      tick(1);
      clear = 1'b0; wr_en = 1'b0;
      chk("clr_wr_count", 32'(count), 32'd0);
      tick(FR + 2);
      for (int d = 0; d < 4; d++) seg_at($sformatf("clr_blank_%0d", d), d, 7'h00);
      wr(6'd50);
      chk("dash_count", 32'(count), 32'd1);
      tick(FR + 2);
      seg_at("dash_seg", 0, 7'h40);

      // Scroll AHLO, then reset at B=2
      do_clear();
      wr(6'd16); wr(6'd24); wr(6'd29); wr(6'd31);
      set_mode(2'b01);
      wait_rel(64);
      seg_at("scroll_b0_d0", 0, 7'h77);
      seg_at("scroll_b0_d1", 1, 7'h76);
      wait_rel(160);
      seg_at("scroll_b1_d0", 0, 7'h76);
      seg_at("scroll_b1_d3", 3, 7'h77);
      wait_rel(544);
      seg_at("scroll_b0_again", 0, 7'h77);
      wait_rel(800);
      seg_at("scroll_b2_d0", 0, 7'h38);
      seg_at("scroll_b2_d1", 1, 7'h3F);
      wait_digit(2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("midrst_dig_sel", 32'(dig_sel), 32'h1);
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_seg", 32'(seg), 32'h0);

      // Blink with code 8
      mode = 2'b00;
      tick(2);
      do_clear();
      wr(6'd8);
      set_mode(2'b10);
      wait_rel(40);
      seg_at("blink_on_1", 0, 7'h7F);
      wait_rel(160);
      seg_at("blink_off_d0", 0, 7'h00);
      wait_digit(1);
      wait_digit(2);
      seg_at("blink_off_d0_again", 0, 7'h00);
      wait_rel(290);
      seg_at("blink_on_2", 0, 7'h7F);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
